// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX fetch front end: fetch FSM encoding,
// halt opcode, NOP word and sequential PC stride.
package dlx_pkg;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  localparam logic [5:0]  HALT_OPCODE_DEFAULT = 6'h3F;
  localparam logic [31:0] NOP_WORD            = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES_DEFAULT = 32'd4;

  function automatic logic is_halt_instr(input logic [31:0] instr,
                                         input logic [5:0]  halt_opcode);
    return (instr[31:26] == halt_opcode);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next fetch PC selection: a redirect beats a hold, and a hold beats the
// sequential increment. Purely combinational.
module pc_next_mux
  import dlx_pkg::*;
#(
  parameter logic [31:0] INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        hold,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next
);

  // Redirect targets are forced word aligned; the add wraps modulo 2^32.
  always_comb begin
    pc_next = pc_cur + INSTR_BYTES;
    if (hold) begin
      pc_next = pc_cur;
    end
    if (redirect) begin
      pc_next = redirect_pc & 32'hFFFF_FFFC;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencer for the DLX pipeline: owns the fetch PC and tracks
// which fetched instruction is valid across stalls, redirects and halt.
module fetch_sequencer
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] INSTR_BYTES = INSTR_BYTES_DEFAULT,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        resume,
  input  logic [31:0] instr_if,
  output logic [31:0] PC,
  output logic [31:0] pc_if,
  output logic        if_valid,
  output logic        flush_if,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_if_q, pc_if_d;
  logic         if_valid_q, if_valid_d;
  logic         take_redirect;
  logic         hold_pc;
  logic         halt_seen;

  assign halt_seen = if_valid_q && is_halt_instr(instr_if, HALT_OPCODE);

  pc_next_mux #(
    .INSTR_BYTES (INSTR_BYTES)
  ) u_pc_next_mux (
    .redirect    (take_redirect),
    .redirect_pc (redirect_pc),
    .hold        (hold_pc),
    .pc_cur      (pc_q),
    .pc_next     (pc_d)
  );

  always_comb begin
    state_d       = state_q;
    pc_if_d       = pc_if_q;
    if_valid_d    = if_valid_q;
    take_redirect = 1'b0;
    hold_pc       = 1'b1;

    case (state_q)
      FETCH_BOOT: begin
        state_d    = FETCH_RUN;
        if_valid_d = 1'b0;
      end

      FETCH_RUN: begin
        if (redirect_valid) begin
          take_redirect = 1'b1;
          if_valid_d    = 1'b0;
        end else if (halt_seen) begin
          state_d    = FETCH_HALT;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          hold_pc    = 1'b0;
          pc_if_d    = pc_q;
          if_valid_d = 1'b1;
        end
      end

      FETCH_HALT: begin
        // An older branch resolving now squashes the halt outright.
        if_valid_d = 1'b0;
        if (redirect_valid) begin
          take_redirect = 1'b1;
          state_d       = FETCH_RUN;
        end else if (resume) begin
          state_d = FETCH_RUN;
        end
      end

      default: begin
        state_d    = FETCH_BOOT;
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH_BOOT;
      pc_q       <= RESET_PC;
      pc_if_q    <= 32'h0000_0000;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_if_q    <= pc_if_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign PC       = pc_q;
  assign pc_if    = pc_if_q;
  assign if_valid = if_valid_q;
  assign flush_if = ~if_valid_q;
  assign halted   = (state_q == FETCH_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each task drives one scenario and
// compares against hand-computed PC / pc_if / valid / halt values.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        resume;
  logic [31:0] instr_if;
  logic [31:0] pc_out;
  logic [31:0] pc_if;
  logic        if_valid;
  logic        flush_if;
  logic        halted;

  int compared;
  int mismatched;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .resume         (resume),
    .instr_if       (instr_if),
    .PC             (pc_out),
    .pc_if          (pc_if),
    .if_valid       (if_valid),
    .flush_if       (flush_if),
    .halted         (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Full view: {PC, pc_if, if_valid, flush_if, halted}
  logic [66:0] full_obs;
  // Partial view where pc_if is left unconstrained: {PC, if_valid, flush_if, halted}
  logic [34:0] part_obs;
  assign full_obs = {pc_out, pc_if, if_valid, flush_if, halted};
  assign part_obs = {pc_out, if_valid, flush_if, halted};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    resume = 1'b0; instr_if = NOP;
    repeat (2) tick();
    compared++;
    if (full_obs !== {32'h0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      $display("[TB] FAIL reset_hold: got %h expected %h", full_obs, {32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
      mismatched++;
    end
    rst = 1'b0;
    tick();
    compared++;
    if (full_obs !== {32'h0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      $display("[TB] FAIL boot_edge: got %h expected %h", full_obs, {32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
      mismatched++;
    end
    tick();
    compared++;
    if (full_obs !== {32'h4, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL first_fetch: got %h expected %h", full_obs, {32'h4, 32'h0, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
    tick();
    compared++;
    if (full_obs !== {32'h8, 32'h4, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL seq_pc8: got %h expected %h", full_obs, {32'h8, 32'h4, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
    tick();
    compared++;
    if (full_obs !== {32'hC, 32'h8, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL seq_pcC: got %h expected %h", full_obs, {32'hC, 32'h8, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
  endtask

  task automatic test_stall();
    tick();
    compared++;
    if (full_obs !== {32'h10, 32'hC, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL pre_stall: got %h expected %h", full_obs, {32'h10, 32'hC, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (full_obs !== {32'h10, 32'hC, 1'b1, 1'b0, 1'b0}) begin
        $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", i, full_obs, {32'h10, 32'hC, 1'b1, 1'b0, 1'b0});
        mismatched++;
      end
    end
    stall = 1'b0;
    tick();
    compared++;
    if (full_obs !== {32'h14, 32'h10, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL stall_release: got %h expected %h", full_obs, {32'h14, 32'h10, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
  endtask

  task automatic test_redirect();
    repeat (3) tick();
    compared++;
    if (full_obs !== {32'h20, 32'h1C, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL pre_redirect: got %h expected %h", full_obs, {32'h20, 32'h1C, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    compared++;
    if (part_obs !== {32'h100, 1'b0, 1'b1, 1'b0}) begin
      $display("[TB] FAIL redirect_over_stall: got %h expected %h", part_obs, {32'h100, 1'b0, 1'b1, 1'b0});
      mismatched++;
    end
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick();
    compared++;
    if (full_obs !== {32'h104, 32'h100, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL redirect_target_valid: got %h expected %h", full_obs, {32'h104, 32'h100, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
  endtask

  task automatic test_halt();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    tick();
    compared++;
    if (full_obs !== {32'h44, 32'h40, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL pre_halt: got %h expected %h", full_obs, {32'h44, 32'h40, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
    instr_if = HALT_WORD;
    tick();
    instr_if = NOP;
    compared++;
    if (part_obs !== {32'h44, 1'b0, 1'b1, 1'b1}) begin
      $display("[TB] FAIL halt_enter: got %h expected %h", part_obs, {32'h44, 1'b0, 1'b1, 1'b1});
      mismatched++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if (part_obs !== {32'h44, 1'b0, 1'b1, 1'b1}) begin
        $display("[TB] FAIL halt_frozen[%0d]: got %h expected %h", i, part_obs, {32'h44, 1'b0, 1'b1, 1'b1});
        mismatched++;
      end
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    compared++;
    if (part_obs !== {32'h44, 1'b0, 1'b1, 1'b0}) begin
      $display("[TB] FAIL resume_edge: got %h expected %h", part_obs, {32'h44, 1'b0, 1'b1, 1'b0});
      mismatched++;
    end
    tick();
    compared++;
    if (full_obs !== {32'h48, 32'h44, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL resume_first_fetch: got %h expected %h", full_obs, {32'h48, 32'h44, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
  endtask

  task automatic test_halt_redirect();
    instr_if = HALT_WORD; stall = 1'b1;
    tick();
    instr_if = NOP;
    compared++;
    if (part_obs !== {32'h48, 1'b0, 1'b1, 1'b1}) begin
      $display("[TB] FAIL halt_beats_stall: got %h expected %h", part_obs, {32'h48, 1'b0, 1'b1, 1'b1});
      mismatched++;
    end
    tick();
    compared++;
    if (part_obs !== {32'h48, 1'b0, 1'b1, 1'b1}) begin
      $display("[TB] FAIL halt_ignores_stall: got %h expected %h", part_obs, {32'h48, 1'b0, 1'b1, 1'b1});
      mismatched++;
    end
    stall = 1'b0; resume = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    resume = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    compared++;
    if (part_obs !== {32'h200, 1'b0, 1'b1, 1'b0}) begin
      $display("[TB] FAIL halt_redirect: got %h expected %h", part_obs, {32'h200, 1'b0, 1'b1, 1'b0});
      mismatched++;
    end
    tick();
    compared++;
    if (full_obs !== {32'h204, 32'h200, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL halt_redirect_fetch: got %h expected %h", full_obs, {32'h204, 32'h200, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
  endtask

  task automatic test_wrap_async_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    compared++;
    if (part_obs !== {32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0}) begin
      $display("[TB] FAIL wrap_redirect: got %h expected %h", part_obs, {32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0});
      mismatched++;
    end
    tick();
    compared++;
    if (full_obs !== {32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL pc_wrap: got %h expected %h", full_obs, {32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
    tick();
    compared++;
    if (full_obs !== {32'h4, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL after_wrap: got %h expected %h", full_obs, {32'h4, 32'h0, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
    #3;
    rst = 1'b1;
    #1;
    compared++;
    if (full_obs !== {32'h0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      $display("[TB] FAIL async_reset: got %h expected %h", full_obs, {32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
      mismatched++;
    end
    #2;
    rst = 1'b0;
    tick();
    compared++;
    if (full_obs !== {32'h0, 32'h0, 1'b0, 1'b1, 1'b0}) begin
      $display("[TB] FAIL reboot_edge: got %h expected %h", full_obs, {32'h0, 32'h0, 1'b0, 1'b1, 1'b0});
      mismatched++;
    end
    tick();
    compared++;
    if (full_obs !== {32'h4, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      $display("[TB] FAIL reboot_fetch: got %h expected %h", full_obs, {32'h4, 32'h0, 1'b1, 1'b0, 1'b0});
      mismatched++;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_stall();
    test_redirect();
    test_halt();
    test_halt_redirect();
    test_wrap_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
